// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, legality check and the
// sequencing states used by units that time-share the ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b0100;
  localparam logic [3:0] OP_SHR = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    // Every legal code has bit 3 clear, and all eight such codes are used.
    return (op[3] == 1'b0);
  endfunction

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu.sv
// The team's combinational 32-bit ALU; the port names are kept as they
// appear in the existing core so the module can be dropped in unchanged.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]  ALUcontrol,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] ALUresult,
  output logic        Zero
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves the output unassigned (no latch).
    ALUresult = '0;
    case (ALUcontrol)
      OP_ADD:  ALUresult = A + B;
      OP_SUB:  ALUresult = A - B;
      OP_AND:  ALUresult = A & B;
      OP_OR:   ALUresult = A | B;
      OP_XOR:  ALUresult = A ^ B;
      OP_MUL:  ALUresult = A * B;
      OP_SHL:  ALUresult = A << B;
      OP_SHR:  ALUresult = A >> B;
      default: ALUresult = '0;
    endcase
  end

  assign Zero = (ALUresult == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or above ptr,
// wrapping at NUM_REQ. Purely combinational; the caller owns the pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one ALU between NUM_REQ requesters: round-robin accept,
// one execute cycle on registered operands, then a held valid/ready response.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [4*NUM_REQ-1:0]      req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [3:0]         op_q;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;
  logic [ID_W-1:0]    id_q;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic [3:0]         sel_op;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic               accept;

  logic [DATA_W-1:0]  alu_b;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_zero;
  logic               op_legal;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign req_ready = (state == IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign busy      = (state != IDLE);

  // One-hot grant steers the granted requester's fields into the capture registers.
  always_comb begin
    grant_idx = '0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = PTR_W'(i);
        sel_op    = req_op[4*i +: 4];
        sel_a     = req_a[DATA_W*i +: DATA_W];
        sel_b     = req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  assign next_ptr = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Shift amounts wrap at the word width, so only B[4:0] reaches the ALU.
  assign alu_b    = is_shift_op(op_q) ? {{(DATA_W-5){1'b0}}, b_q[4:0]} : b_q;
  assign op_legal = is_legal_op(op_q);

  alu u_alu (
    .ALUcontrol (op_q),
    .A          (a_q),
    .B          (alu_b),
    .ALUresult  (alu_result),
    .Zero       (alu_zero)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      // NOTE: operand/opcode registers are reset too, so the ALU never sees X after reset.
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= sel_op;
            a_q    <= sel_a;
            b_q    <= sel_b;
            id_q   <= ID_W'(grant_idx);
            rr_ptr <= next_ptr;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= op_legal ? alu_result : '0;
          rsp_zero   <= op_legal ? alu_zero : 1'b1;
          rsp_err    <= !op_legal;
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
